// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer that forms a wide unsigned product
// one 3x3 digit-pair partial product per cycle, reusing mult_3x3.

module mult_3x3 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [5:0] prod
);

    logic [2:0] row0;
    logic [2:0] row1;
    logic [2:0] row2;

    // AND-array rows shifted into place and summed
    always_comb begin
        row0 = x & {3{y[0]}};
        row1 = x & {3{y[1]}};
        row2 = x & {3{y[2]}};
        prod = {3'b000, row0}
             + {2'b00, row1, 1'b0}
             + {1'b0, row2, 2'b00};
    end

endmodule

module mult_seq_ctrl #(
    parameter int N_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*N_DIGITS-1:0]   a,
    input  logic [3*N_DIGITS-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6*N_DIGITS-1:0]   p,
    output logic                    busy
);

    localparam int W  = 3 * N_DIGITS;
    localparam int PW = 2 * W;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = $clog2(PW) + 1;

    localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [PW-1:0] acc;
    logic [IW-1:0] i;
    logic [IW-1:0] j;

    logic [2:0]    a_dig;
    logic [2:0]    b_dig;
    logic [5:0]    pp;
    logic [SW-1:0] sh;
    logic [PW-1:0] pp_sh;
    logic [PW-1:0] acc_nxt;

    mult_3x3 u_mult (
        .x    (a_dig),
        .y    (b_dig),
        .prod (pp)
    );

    // select current digit pair and align its partial product
    always_comb begin
        a_dig   = a_q[3*i +: 3];
        b_dig   = b_q[3*j +: 3];
        sh      = SW'(3) * (SW'(i) + SW'(j));
        pp_sh   = PW'(pp) << sh;
        acc_nxt = acc + pp_sh;
    end

    // IDLE only accepts, and never while reset is held
    assign in_ready = (state == IDLE) && !rst;

    // control FSM with registered outputs and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            p         <= acc_nxt;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            i <= i + ONE;
                        end
                    end else begin
                        j <= j + ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
